// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// fetch_pkg : shared state encoding and reset constant for the fetch controller
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      REQUEST = 2'd1,
      WAIT    = 2'd2,
      HOLD    = 2'd3
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_controller.sv
//------------------------------------------------------------------------------
// fetch_controller : single-outstanding instruction fetch with redirect/kill
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_controller
   import fetch_pkg::*;
#(
   parameter int                  PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEFAULT)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   input  logic                stall,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_gnt,
   input  logic                imem_rvalid,
   input  logic [PC_WIDTH-1:0] imem_rdata,
   output logic                fetch_valid,
   output logic [PC_WIDTH-1:0] fetch_pc,
   output logic [PC_WIDTH-1:0] fetch_instr,
   output logic [PC_WIDTH-1:0] pc_plusfour
);

   localparam logic [PC_WIDTH-1:0] c_pc_step = PC_WIDTH'(4);

   fetch_state_t        r_state;
   fetch_state_t        w_state_nxt;
   logic [PC_WIDTH-1:0] r_pc;
   logic [PC_WIDTH-1:0] w_pc_nxt;
   logic [PC_WIDTH-1:0] w_redir_pc;
   logic [PC_WIDTH-1:0] r_fetch_pc;
   logic [PC_WIDTH-1:0] r_fetch_instr;
   logic                r_kill;
   logic                w_kill_nxt;
   logic                r_fetch_valid;
   logic                w_valid_nxt;
   logic                w_load;
   logic                w_req;
   logic                w_unused_bits;

   // Redirect targets are word aligned; the low two bits are dropped.
   assign w_redir_pc    = {redirect_pc[PC_WIDTH-1:2], 2'b00};
   assign w_unused_bits = ^redirect_pc[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= BOOT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_kill_nxt  = r_kill;
      w_valid_nxt = r_fetch_valid;
      w_load      = 1'b0;
      w_req       = 1'b0;

      case (r_state)
         BOOT: begin
            w_state_nxt = REQUEST;
         end

         REQUEST: begin
            w_req = 1'b1;
            if (redirect_valid) begin
               w_pc_nxt = w_redir_pc;
            end
            if (imem_gnt) begin
               // A redirect accepted alongside the grant poisons that response.
               w_state_nxt = WAIT;
               w_kill_nxt  = redirect_valid;
            end
         end

         WAIT: begin
            if (imem_rvalid) begin
               if (redirect_valid || r_kill) begin
                  w_kill_nxt  = 1'b0;
                  w_state_nxt = REQUEST;
                  if (redirect_valid) begin
                     w_pc_nxt = w_redir_pc;
                  end
               end else begin
                  w_load      = 1'b1;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = HOLD;
               end
            end else if (redirect_valid) begin
               w_pc_nxt   = w_redir_pc;
               w_kill_nxt = 1'b1;
            end
         end

         HOLD: begin
            if (redirect_valid) begin
               w_valid_nxt = 1'b0;
               w_pc_nxt    = w_redir_pc;
               w_state_nxt = REQUEST;
            end else if (!stall) begin
               w_valid_nxt = 1'b0;
               w_pc_nxt    = r_pc + c_pc_step;
               w_state_nxt = REQUEST;
            end
         end

         default: begin
            w_state_nxt = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_VECTOR;
         r_kill        <= 1'b0;
         r_fetch_valid <= 1'b0;
         r_fetch_pc    <= RESET_VECTOR;
         r_fetch_instr <= '0;
      end else begin
         r_pc          <= w_pc_nxt;
         r_kill        <= w_kill_nxt;
         r_fetch_valid <= w_valid_nxt;
         if (w_load) begin
            r_fetch_pc    <= r_pc;
            r_fetch_instr <= imem_rdata;
         end
      end
   end

   // No request may escape while reset is held, whatever the current state.
   assign imem_req    = w_req & ~rst;
   assign imem_addr   = r_pc;
   assign fetch_valid = r_fetch_valid;
   assign fetch_pc    = r_fetch_pc;
   assign fetch_instr = r_fetch_instr;
   assign pc_plusfour = r_fetch_pc + c_pc_step;

endmodule

`default_nettype wire

// File: tb/tb_fetch_controller.sv
//------------------------------------------------------------------------------
// tb_fetch_controller : directed vector table plus randomized reference check
// Revision            : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_controller;

   localparam logic [31:0] RV = 32'hBFC00000;

   logic        clk = 1'b0;
   logic        rst, redirect_valid, stall, imem_gnt, imem_rvalid;
   logic [31:0] redirect_pc, imem_rdata;
   logic        imem_req, fetch_valid;
   logic [31:0] imem_addr, fetch_pc, fetch_instr, pc_plusfour;

   int errors = 0;
   int checks = 0;

   fetch_controller #(.PC_WIDTH(32), .RESET_VECTOR(RV)) dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .fetch_valid(fetch_valid),
      .fetch_pc(fetch_pc), .fetch_instr(fetch_instr), .pc_plusfour(pc_plusfour)
   );

   always #5 clk = ~clk;

   // Transaction-level reference: where the fetcher is in its life cycle is
   // described by flags (starting up / response owed / response poisoned / holding).
   logic        m_boot, m_owed, m_poison, m_holding;
   logic [31:0] m_pc, m_fpc, m_finstr;

   task automatic model_step();
      logic [31:0] tgt;
      tgt = redirect_pc & 32'hFFFF_FFFC;
      if (rst) begin
         m_boot = 1; m_owed = 0; m_poison = 0; m_holding = 0;
         m_pc = RV; m_fpc = RV; m_finstr = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (m_holding) begin
         if (redirect_valid) begin m_holding = 0; m_pc = tgt; end
         else if (!stall) begin m_holding = 0; m_pc = m_pc + 32'd4; end
      end else if (m_owed) begin
         if (imem_rvalid) begin
            m_owed = 0;
            if (redirect_valid) begin m_pc = tgt; m_poison = 0; end
            else if (m_poison) m_poison = 0;
            else begin m_holding = 1; m_fpc = m_pc; m_finstr = imem_rdata; end
         end else if (redirect_valid) begin
            m_pc = tgt; m_poison = 1;
         end
      end else begin
         if (redirect_valid) m_pc = tgt;
         if (imem_gnt) begin m_owed = 1; m_poison = redirect_valid; end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   typedef struct {
      logic        rst, redir;
      logic [31:0] rpc;
      logic        stall, gnt, rvalid;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_fpc, e_instr;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic rd, input logic [31:0] rpc, input logic st,
                      input logic g, input logic rv, input logic [31:0] dat,
                      input logic e_req, input logic [31:0] e_addr, input logic e_v,
                      input logic [31:0] e_fpc, input logic [31:0] e_in);
      vec_t v;
      v.rst = r; v.redir = rd; v.rpc = rpc; v.stall = st; v.gnt = g; v.rvalid = rv;
      v.rdata = dat; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_v;
      v.e_fpc = e_fpc; v.e_instr = e_in;
      vq.push_back(v);
   endtask

   initial begin
      logic [31:0] i1, i2, i4, i5, xx;
      i1 = 32'h1111_0001; i2 = 32'h2222_0002; i4 = 32'h4444_0004;
      i5 = 32'h5555_0005; xx = 32'hDEAD_BEEF;

      rst = 1; redirect_valid = 0; redirect_pc = 0; stall = 0;
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
      tick(); tick();

      //   rst rd rpc           st g rv data   req addr          v fpc           instr
      add(1, 0, 0,            0, 0, 0, 0,    0, RV,           0, RV,           0);   // reset state
      add(0, 0, 0,            0, 1, 0, 0,    0, RV,           0, RV,           0);   // boot cycle
      add(0, 0, 0,            0, 1, 0, 0,    1, RV,           0, RV,           0);
      add(0, 0, 0,            0, 0, 1, i1,   0, RV,           0, RV,           0);
      add(0, 0, 0,            0, 0, 0, 0,    0, RV,           1, RV,           i1);
      add(0, 0, 0,            0, 1, 0, 0,    1, RV+4,         0, RV,           i1);
      add(0, 0, 0,            0, 0, 1, i2,   0, RV+4,         0, RV,           i1);
      for (int k = 0; k < 5; k++)
         add(0, 0, 0,         1, 0, 0, 0,    0, RV+4,         1, RV+4,         i2);  // stalled
      add(0, 0, 0,            0, 0, 0, 0,    0, RV+4,         1, RV+4,         i2);
      add(0, 0, 0,            0, 0, 0, 0,    1, RV+8,         0, RV+4,         i2);
      add(0, 0, 0,            0, 1, 0, 0,    1, RV+8,         0, RV+4,         i2);
      add(0, 1, 32'h1003,     0, 0, 0, 0,    0, RV+8,         0, RV+4,         i2);  // redirect in WAIT
      add(0, 0, 0,            0, 0, 1, xx,   0, 32'h1000,     0, RV+4,         i2);  // killed response
      add(0, 1, 32'hFFFFFFFF, 0, 1, 0, 0,    1, 32'h1000,     0, RV+4,         i2);  // redirect + gnt
      add(0, 0, 0,            0, 0, 1, xx,   0, 32'hFFFFFFFC, 0, RV+4,         i2);
      add(0, 0, 0,            0, 1, 0, 0,    1, 32'hFFFFFFFC, 0, RV+4,         i2);
      add(0, 0, 0,            0, 0, 1, i4,   0, 32'hFFFFFFFC, 0, RV+4,         i2);
      add(0, 0, 0,            0, 0, 0, 0,    0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, i4);
      add(0, 0, 0,            0, 0, 1, xx,   1, 32'h0,        0, 32'hFFFFFFFC, i4);  // wrap
      add(0, 0, 0,            0, 1, 0, 0,    1, 32'h0,        0, 32'hFFFFFFFC, i4);
      add(1, 0, 0,            0, 0, 0, 0,    0, 32'h0,        0, 32'hFFFFFFFC, i4);  // rst in WAIT
      add(0, 1, 32'h5000,     0, 0, 1, xx,   0, RV,           0, RV,           0);   // late rvalid in BOOT
      add(0, 0, 0,            0, 0, 1, xx,   1, RV,           0, RV,           0);
      add(0, 0, 0,            0, 1, 0, 0,    1, RV,           0, RV,           0);
      add(0, 1, 32'h2000,     0, 0, 1, xx,   0, RV,           0, RV,           0);   // redirect with rvalid
      add(0, 0, 0,            0, 1, 0, 0,    1, 32'h2000,     0, RV,           0);
      add(0, 0, 0,            0, 0, 1, i5,   0, 32'h2000,     0, RV,           0);
      add(0, 1, 32'h3002,     1, 0, 0, 0,    0, 32'h2000,     1, 32'h2000,     i5);  // redirect in HOLD
      add(0, 1, 32'h4000,     0, 0, 0, 0,    1, 32'h3000,     0, 32'h2000,     i5);
      add(0, 0, 0,            0, 0, 0, 0,    1, 32'h4000,     0, 32'h2000,     i5);

      foreach (vq[n]) begin
         rst = vq[n].rst; redirect_valid = vq[n].redir; redirect_pc = vq[n].rpc;
         stall = vq[n].stall; imem_gnt = vq[n].gnt; imem_rvalid = vq[n].rvalid;
         imem_rdata = vq[n].rdata;
         #3;
         chk($sformatf("v%0d imem_req", n), {31'b0, imem_req}, {31'b0, vq[n].e_req});
         if (vq[n].e_req)
            chk($sformatf("v%0d imem_addr", n), imem_addr, vq[n].e_addr);
         chk($sformatf("v%0d fetch_valid", n), {31'b0, fetch_valid}, {31'b0, vq[n].e_valid});
         chk($sformatf("v%0d fetch_pc", n), fetch_pc, vq[n].e_fpc);
         chk($sformatf("v%0d fetch_instr", n), fetch_instr, vq[n].e_instr);
         chk($sformatf("v%0d pc_plusfour", n), pc_plusfour, vq[n].e_fpc + 32'd4);
         tick();
      end

      rst = 1; redirect_valid = 0; imem_gnt = 0; imem_rvalid = 0;
      tick();
      for (int c = 0; c < 3000; c++) begin
         logic e_req;
         rst            = ($urandom_range(0, 99) == 0);
         redirect_valid = ($urandom_range(0, 99) < 15);
         redirect_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF : $urandom;
         stall          = $urandom_range(0, 1);
         imem_gnt       = $urandom_range(0, 1);
         imem_rvalid    = $urandom_range(0, 1);
         imem_rdata     = $urandom;
         #3;
         e_req = !rst && !m_boot && !m_owed && !m_holding;
         chk("rnd imem_req", {31'b0, imem_req}, {31'b0, e_req});
         if (e_req) chk("rnd imem_addr", imem_addr, m_pc);
         chk("rnd fetch_valid", {31'b0, fetch_valid}, {31'b0, m_holding});
         chk("rnd fetch_pc", fetch_pc, m_fpc);
         chk("rnd fetch_instr", fetch_instr, m_finstr);
         chk("rnd pc_plusfour", pc_plusfour, m_fpc + 32'd4);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32: width of all addresses and instruction words.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'hBFC00000: first fetch address after reset.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port redirect_valid, input, 1: branch/jump taken this cycle.
REQ-006 SHALL have port redirect_pc, input, PC_WIDTH: redirect target.
REQ-007 SHALL have port stall, input, 1: downstream cannot accept the held instruction.
REQ-008 SHALL have port imem_req, output, 1: fetch request to instruction memory.
REQ-009 SHALL have port imem_addr, output, PC_WIDTH: request address.
REQ-010 SHALL have port imem_gnt, input, 1: memory accepts the request this cycle.
REQ-011 SHALL have port imem_rvalid, input, 1: response data valid.
REQ-012 SHALL have port imem_rdata, input, PC_WIDTH: response instruction.
REQ-013 SHALL have port fetch_valid, output, 1: fetch_instr/fetch_pc hold a live instruction.
REQ-014 SHALL have port fetch_pc, output, PC_WIDTH: address of the held instruction.
REQ-015 SHALL have port fetch_instr, output, PC_WIDTH: held instruction.
REQ-016 SHALL have port pc_plusfour, output, PC_WIDTH: fetch_pc + 4, combinational.

Function
REQ-017 SHALL implement FSM states BOOT, REQUEST, WAIT, HOLD, with one memory transaction outstanding at most.
REQ-018 BOOT SHALL last exactly one cycle after rst deasserts, then go to REQUEST; redirect_valid is ignored in BOOT.
REQ-019 REQUEST SHALL drive imem_req=1 and imem_addr=pc; on imem_gnt it SHALL go to WAIT, otherwise it stays in REQUEST with imem_addr stable.
REQ-020 WAIT SHALL drive imem_req=0; on imem_rvalid with kill=0 it SHALL load fetch_instr=imem_rdata and fetch_pc=pc, set fetch_valid=1 next cycle, and go to HOLD.
REQ-021 HOLD SHALL keep all fetch_* outputs stable while stall=1; when stall=0 it SHALL clear fetch_valid, set pc=pc+4, and go to REQUEST.
REQ-022 Redirect SHALL have priority over stall and sequential advance in every state except BOOT; pc is loaded with redirect_pc with bits [1:0] forced to 0.
REQ-023 Redirect in REQUEST without imem_gnt SHALL update pc and stay in REQUEST; the new address appears on imem_addr the next cycle.
REQ-024 Redirect in REQUEST with imem_gnt, or in WAIT without imem_rvalid, SHALL set a kill flag and go to or stay in WAIT.
REQ-025 imem_rvalid with kill=1 SHALL be discarded (fetch_valid stays 0), clear kill, and go to REQUEST.
REQ-026 Redirect in WAIT coinciding with imem_rvalid SHALL discard the response and go to REQUEST with the redirected pc.
REQ-027 Redirect in HOLD SHALL clear fetch_valid next cycle regardless of stall and go to REQUEST.
REQ-028 pc+4 SHALL wrap modulo 2^PC_WIDTH (32'hFFFFFFFC -> 32'h00000000).
REQ-029 imem_rvalid received in REQUEST, HOLD or BOOT SHALL be ignored.

Reset
REQ-030 While rst=1 (sampled on posedge): state=BOOT, pc=RESET_VECTOR, kill=0, fetch_valid=0, fetch_pc=RESET_VECTOR, fetch_instr=0, imem_req=0.
REQ-031 rst asserted mid-transaction SHALL abandon it; a late imem_rvalid arriving in BOOT/REQUEST is dropped per REQ-029.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum (fetch_state_t) and the RESET_VECTOR default constant.
REQ-033 The pc register, next-pc mux and kill flag SHALL be implemented inline; no sub-module is required.

Verification
REQ-034 Reset then gnt and rvalid each after 1 cycle, stall=0 -> imem_addr sequence BFC00000, BFC00004, BFC00008; each fetch_valid pulse lasts one cycle.
REQ-035 stall=1 for 5 cycles in HOLD -> fetch_pc and fetch_instr unchanged, no imem_req; stall=0 -> next imem_addr = fetch_pc+4.
REQ-036 Redirect to 0x00001003 in WAIT, followed by rvalid -> response dropped, fetch_valid=0, next imem_addr=0x00001000.
REQ-037 Redirect and imem_gnt in the same cycle in REQUEST -> the next response is killed; the following request goes to the redirect target.
REQ-038 Redirect to 0xFFFFFFFC, then advance -> next imem_addr=0x00000000.
REQ-039 rst pulsed in WAIT, then rvalid arrives in BOOT -> ignored; first request goes to BFC00000.
